dpram_port_initiator: RTL and testbench

Single-port initiator that drives one port (A or B) of the team's `dual_port_ram_64bit` through its address, write and read valid/ready channels. It sits between an upstream command/response interface and the RAM port. Each accepted command becomes exactly one RAM access, or an immediate error for a write to the protected low region. Every command returns exactly one response carrying read data and an error flag.

---
 rtl/dpram_port_initiator.sv | 132 +++++++++++++
 tb/tb_dpram_port_initiator.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_initiator.sv
// dpram_port_initiator: turns one upstream cmd (valid/ready) into one RAM port access and returns one rsp with rdata/err; mem_* ports drive one side of dual_port_ram_64bit
module dpram_port_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BUS_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_we,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_addr_valid,
  input  logic                  mem_addr_ready,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  output logic                  mem_valid_w,
  input  logic                  mem_ready_w,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_valid_r,
  output logic                  mem_ready_r
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, WADDR, RADDR, RDATA, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BUS_WIDTH-1:0] mem_wdata_q, mem_wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic rsp_we_q, rsp_we_d, rsp_err_q, rsp_err_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, mem_en_q, mem_en_d;
  logic mem_we_q, mem_we_d, mem_addr_valid_q, mem_addr_valid_d;
  logic mem_valid_w_q, mem_valid_w_d, mem_ready_r_q, mem_ready_r_d;
  logic accept, prot, done;
  always_comb begin
    accept = cmd_valid && cmd_ready_q;
    prot = cmd_addr[ADDR_WIDTH-1:13] == '0;
    done = state_q == WADDR ? mem_addr_ready && mem_ready_w : state_q == RADDR ? mem_addr_ready : mem_valid_r;
    state_d = state_q;
    cnt_d = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_we_d = rsp_we_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = !cmd_we ? RADDR : prot ? RESP : WADDR;
        cnt_d = '0;
        mem_addr_d = cmd_addr;
        mem_wdata_d = cmd_wdata;
        rsp_we_d = cmd_we;
        rsp_err_d = cmd_we && prot;
        rsp_rdata_d = '0;
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rsp_rdata_d = '0;
        rsp_err_d = 1'b0;
        rsp_we_d = 1'b0;
      end
      default: if (done) begin
        state_d = state_q == RADDR ? RDATA : RESP;
        rsp_rdata_d = state_q == RDATA ? mem_rdata : rsp_rdata_q;
      end else if (cnt_q == LAST) begin
        state_d = RESP;
        rsp_err_d = 1'b1;
        rsp_rdata_d = '0;
      end
    endcase
    cmd_ready_d = state_d == IDLE;
    rsp_valid_d = state_d == RESP;
    mem_en_d = 1'b1;
    mem_addr_valid_d = state_d == WADDR || state_d == RADDR;
    mem_valid_w_d = state_d == WADDR;
    mem_we_d = state_d == WADDR;
    mem_ready_r_d = state_d == RDATA;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_we_q <= 1'b0;
      rsp_err_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_addr_valid_q <= 1'b0;
      mem_valid_w_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_ready_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_we_q <= rsp_we_d;
      rsp_err_q <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      mem_en_q <= mem_en_d;
      mem_addr_valid_q <= mem_addr_valid_d;
      mem_valid_w_q <= mem_valid_w_d;
      mem_we_q <= mem_we_d;
      mem_ready_r_q <= mem_ready_r_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_we = rsp_we_q;
  assign rsp_err = rsp_err_q;
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_addr_valid = mem_addr_valid_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_valid_w = mem_valid_w_q;
  assign mem_ready_r = mem_ready_r_q;
endmodule

// File: tb/tb_dpram_port_initiator.sv
// tb_dpram_port_initiator: randomized and directed checks of dpram_port_initiator against a behavioural RAM stub and a spec-level response model
module tb_dpram_port_initiator;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_we, rsp_err, mem_en, mem_we, mem_addr_valid, mem_valid_w, mem_ready_r;
  logic [63:0] rsp_rdata, mem_wdata;
  logic [31:0] mem_addr;
  logic mem_addr_ready, mem_ready_w, mem_valid_r;
  logic [63:0] mem_rdata;
  int checks = 0, failures = 0;
  int stub_mode = 0;
  bit release_w = 0, av_seen = 0;
  logic [63:0] stub_mem [logic [31:0]];
  logic [63:0] model_mem [logic [31:0]];
  logic [31:0] rd_addr = '0;
  always #5 clk = ~clk;
  dpram_port_initiator #(.ADDR_WIDTH(32), .BUS_WIDTH(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_we(rsp_we), .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready),
    .mem_wdata(mem_wdata), .mem_valid_w(mem_valid_w), .mem_ready_w(mem_ready_w),
    .mem_rdata(mem_rdata), .mem_valid_r(mem_valid_r), .mem_ready_r(mem_ready_r)
  );
  always @(posedge clk) if (mem_addr_valid) av_seen = 1;
  initial begin
    mem_addr_ready = 0;
    mem_ready_w = 0;
    mem_valid_r = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_addr_ready = stub_mode == 0 ? 1'b1 : stub_mode == 1 ? ($urandom_range(0, 3) != 0) : stub_mode == 3 ? ~mem_addr_ready : 1'b0;
      mem_ready_w = stub_mode == 0 ? 1'b1 : stub_mode == 1 ? ($urandom_range(0, 3) != 0) : stub_mode == 3 ? release_w : 1'b0;
      mem_valid_r = stub_mode == 0 ? 1'b1 : stub_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
      if (!rst) begin
        if (mem_addr_valid && mem_addr_ready && mem_valid_w && mem_ready_w && mem_we) stub_mem[mem_addr] = mem_wdata;
        if (mem_addr_valid && mem_addr_ready && !mem_valid_w) rd_addr = mem_addr;
      end
      mem_rdata = stub_mem.exists(rd_addr) ? stub_mem[rd_addr] : 64'h0;
    end
  end
  task automatic do_cmd(input logic we, input logic [31:0] a, input logic [63:0] d, input int rsp_delay,
                        output logic [63:0] rdata, output logic err, output logic rwe, output int lat,
                        output logic [3:0] mv, output bit got);
    int n;
    got = 0;
    rdata = '0;
    err = 0;
    rwe = 0;
    mv = '0;
    @(negedge clk);
    cmd_valid = 1;
    cmd_we = we;
    cmd_addr = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 0;
    cmd_we = ~we;
    cmd_addr = $urandom;
    cmd_wdata = {$urandom, $urandom};
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) return;
    got = 1;
    rdata = rsp_rdata;
    err = rsp_err;
    rwe = rsp_we;
    mv = {mem_addr_valid, mem_valid_w, mem_ready_r, mem_we};
    repeat (rsp_delay) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_we, mem_en, mem_we, mem_addr_valid, mem_valid_w, mem_ready_r} !== 9'b0 ||
        rsp_rdata !== 64'h0 || mem_addr !== 32'h0 || mem_wdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_outputs got ctl=%b rdata=%h addr=%h wdata=%h exp all zero",
               {cmd_ready, rsp_valid, rsp_err, rsp_we, mem_en, mem_we, mem_addr_valid, mem_valid_w, mem_ready_r}, rsp_rdata, mem_addr, mem_wdata);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, mem_en} !== 2'b11) begin
      failures++;
      $display("FAIL post_reset got cmd_ready=%b mem_en=%b exp 1 1", cmd_ready, mem_en);
    end
  endtask
  task automatic test_write_read;
    logic [63:0] rd;
    logic er, rw;
    logic [3:0] mv;
    int lat;
    bit got;
    stub_mode = 0;
    do_cmd(1, 32'h2000, 64'hDEAD_BEEF_0123_4567, 0, rd, er, rw, lat, mv, got);
    model_mem[32'h2000] = 64'hDEAD_BEEF_0123_4567;
    checks++;
    if (!got || er !== 0 || rw !== 1 || rd !== 64'h0 || lat != 1) begin
      failures++;
      $display("FAIL write_2000 got got=%0d err=%b we=%b rdata=%h lat=%0d exp 1 0 1 0 1", got, er, rw, rd, lat);
    end
    do_cmd(0, 32'h2000, 64'h0, 0, rd, er, rw, lat, mv, got);
    checks++;
    if (!got || er !== 0 || rw !== 0 || rd !== model_mem[32'h2000] || lat != 2) begin
      failures++;
      $display("FAIL read_2000 got got=%0d err=%b we=%b rdata=%h lat=%0d exp 1 0 0 %h 2", got, er, rw, rd, lat, model_mem[32'h2000]);
    end
  endtask
  task automatic test_protected;
    logic [63:0] rd;
    logic er, rw;
    logic [3:0] mv;
    int lat;
    bit got;
    stub_mode = 0;
    av_seen = 0;
    do_cmd(1, 32'h1FFF, 64'h55, 0, rd, er, rw, lat, mv, got);
    checks++;
    if (!got || er !== 1 || rd !== 64'h0 || lat != 0 || av_seen) begin
      failures++;
      $display("FAIL protected_write got got=%0d err=%b rdata=%h lat=%0d av_seen=%0d exp 1 1 0 0 0", got, er, rd, lat, av_seen);
    end
    do_cmd(0, 32'h1FFF, 64'h0, 0, rd, er, rw, lat, mv, got);
    checks++;
    if (!got || er !== 0 || rd === 64'h55 || rd !== 64'h0) begin
      failures++;
      $display("FAIL protected_read got got=%0d err=%b rdata=%h exp 1 0 0", got, er, rd);
    end
  endtask
  task automatic test_ready_w_hold;
    logic [63:0] rd;
    logic er, rw;
    logic [3:0] mv;
    int lat, n;
    bit got, committed;
    logic both;
    stub_mode = 3;
    release_w = 0;
    committed = 0;
    fork
      do_cmd(1, 32'h2345, 64'hA5A5_0000_FFFF_1234, 0, rd, er, rw, lat, mv, got);
      begin
        n = 0;
        do begin
          @(negedge clk);
          #2;
          n++;
        end while (!mem_valid_w && n < 10);
        for (int c = 0; c < 14 && !committed; c++) begin
          if (c == 5) release_w = 1;
          both = mem_addr_ready && mem_ready_w;
          checks++;
          if (mem_valid_w !== 1 || mem_addr_valid !== 1 || mem_we !== 1) begin
            failures++;
            $display("FAIL ready_w_hold_valids c=%0d got valid_w=%b addr_valid=%b we=%b exp 1 1 1", c, mem_valid_w, mem_addr_valid, mem_we);
          end
          @(negedge clk);
          #2;
          checks++;
          if (rsp_valid !== both) begin
            failures++;
            $display("FAIL ready_w_commit_edge c=%0d got rsp_valid=%b exp %b", c, rsp_valid, both);
          end
          committed = both;
        end
      end
    join
    release_w = 0;
    stub_mode = 0;
    model_mem[32'h2345] = 64'hA5A5_0000_FFFF_1234;
    checks++;
    if (!got || !committed || er !== 0 || !stub_mem.exists(32'h2345) || stub_mem[32'h2345] !== model_mem[32'h2345]) begin
      failures++;
      $display("FAIL ready_w_result got got=%0d committed=%0d err=%b exp 1 1 0 and RAM written", got, committed, er);
    end
  endtask
  task automatic test_timeout;
    logic [63:0] rd;
    logic er, rw;
    logic [3:0] mv;
    int lat;
    bit got;
    stub_mode = 2;
    do_cmd(0, 32'h2800, 64'h0, 0, rd, er, rw, lat, mv, got);
    checks++;
    if (!got || lat != 16 || er !== 1 || rd !== 64'h0 || mv !== 4'b0) begin
      failures++;
      $display("FAIL timeout_read got got=%0d lat=%0d err=%b rdata=%h mv=%b exp 1 16 1 0 0000", got, lat, er, rd, mv);
    end
    do_cmd(1, 32'h2801, 64'h1234, 0, rd, er, rw, lat, mv, got);
    checks++;
    if (!got || lat != 16 || er !== 1 || rd !== 64'h0 || mv !== 4'b0 || stub_mem.exists(32'h2801)) begin
      failures++;
      $display("FAIL timeout_write got got=%0d lat=%0d err=%b rdata=%h mv=%b exp 1 16 1 0 0000", got, lat, er, rd, mv);
    end
    stub_mode = 0;
  endtask
  task automatic test_backpressure;
    logic [63:0] rd, d, seen;
    logic er, rw;
    logic [3:0] mv;
    int lat, n;
    bit got;
    stub_mode = 0;
    d = {$urandom, $urandom};
    do_cmd(1, 32'h3000, d, 0, rd, er, rw, lat, mv, got);
    model_mem[32'h3000] = d;
    fork
      do_cmd(0, 32'h3000, 64'h0, 10, rd, er, rw, lat, mv, got);
      begin
        n = 0;
        do begin
          @(negedge clk);
          #1;
          n++;
        end while (!rsp_valid && n < 20);
        seen = rsp_rdata;
        for (int i = 0; i < 10; i++) begin
          checks++;
          if (rsp_valid !== 1 || rsp_rdata !== model_mem[32'h3000] || cmd_ready !== 0) begin
            failures++;
            $display("FAIL backpressure_hold i=%0d got valid=%b rdata=%h cmd_ready=%b exp 1 %h 0", i, rsp_valid, rsp_rdata, cmd_ready, model_mem[32'h3000]);
          end
          @(negedge clk);
          #1;
        end
      end
    join
    checks++;
    if (!got || rd !== model_mem[32'h3000] || rsp_valid !== 0 || cmd_ready !== 1) begin
      failures++;
      $display("FAIL backpressure_release got got=%0d rdata=%h rsp_valid=%b cmd_ready=%b exp 1 %h 0 1", got, rd, rsp_valid, cmd_ready, model_mem[32'h3000]);
    end
    do_cmd(1, 32'h3001, 64'h77, 0, rd, er, rw, lat, mv, got);
    model_mem[32'h3001] = 64'h77;
    checks++;
    if (!got || er !== 0 || lat != 1) begin
      failures++;
      $display("FAIL backpressure_next got got=%0d err=%b lat=%0d exp 1 0 1", got, er, lat);
    end
  endtask
  task automatic test_reset_mid;
    logic [63:0] rd;
    logic er, rw;
    logic [3:0] mv;
    int lat;
    bit got, stray;
    stub_mode = 3;
    release_w = 0;
    @(negedge clk);
    cmd_valid = 1;
    cmd_we = 1;
    cmd_addr = 32'h4000;
    cmd_wdata = 64'hCAFE;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    checks++;
    if (mem_valid_w !== 1) begin
      failures++;
      $display("FAIL reset_mid_in_waddr got valid_w=%b exp 1", mem_valid_w);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_we, mem_en, mem_we, mem_addr_valid, mem_valid_w, mem_ready_r} !== 9'b0 ||
        rsp_rdata !== 64'h0 || mem_addr !== 32'h0 || mem_wdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs got ctl=%b rdata=%h addr=%h wdata=%h exp all zero",
               {cmd_ready, rsp_valid, rsp_err, rsp_we, mem_en, mem_we, mem_addr_valid, mem_valid_w, mem_ready_r}, rsp_rdata, mem_addr, mem_wdata);
    end
    rst = 0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 0 || cmd_ready !== 1) stray = 1;
    end
    checks++;
    if (stray || stub_mem.exists(32'h4000)) begin
      failures++;
      $display("FAIL reset_mid_dropped got stray=%0d written=%0d exp 0 0", stray, stub_mem.exists(32'h4000));
    end
    stub_mode = 0;
    do_cmd(1, 32'h4000, 64'hBEEF, 0, rd, er, rw, lat, mv, got);
    model_mem[32'h4000] = 64'hBEEF;
    do_cmd(0, 32'h4000, 64'h0, 0, rd, er, rw, lat, mv, got);
    checks++;
    if (!got || er !== 0 || rd !== model_mem[32'h4000]) begin
      failures++;
      $display("FAIL reset_mid_next got got=%0d err=%b rdata=%h exp 1 0 %h", got, er, rd, model_mem[32'h4000]);
    end
  endtask
  task automatic test_random;
    logic [63:0] rd, d, exp_rd;
    logic er, rw, we, exp_err;
    logic [3:0] mv;
    logic [31:0] a;
    int lat;
    bit got;
    stub_mode = 1;
    for (int i = 0; i < 40; i++) begin
      we = $urandom_range(0, 1);
      a = $urandom_range(0, 2) == 0 ? 32'h1FF8 + $urandom_range(0, 7) : 32'h2000 + $urandom_range(0, 15);
      d = {$urandom, $urandom};
      exp_err = we && a < 32'h2000;
      exp_rd = we ? 64'h0 : model_mem.exists(a) ? model_mem[a] : 64'h0;
      if (we && !exp_err) model_mem[a] = d;
      do_cmd(we, a, d, $urandom_range(0, 3), rd, er, rw, lat, mv, got);
      checks++;
      if (!got || er !== exp_err || rd !== exp_rd || rw !== we) begin
        failures++;
        $display("FAIL random_%0d addr=%h we=%b got got=%0d err=%b rdata=%h rwe=%b exp err=%b rdata=%h", i, a, we, got, er, rd, rw, exp_err, exp_rd);
      end
    end
    stub_mode = 0;
  endtask
  initial begin
    test_reset;
    test_write_read;
    test_protected;
    test_ready_w_hold;
    test_timeout;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
